td4e_reg_set: RTL and testbench
===============================

Name: td4e_reg_set

Overview:
- Architectural register set for the TD4E 4-bit CPU.
- Holds general registers A and B, output port register Out, program counter PC, ROM bank register, RAM page register and the carry flag.
- Combines the plain load-enable register behaviour (gen_reg) and the load-or-increment program counter (inc_reg) in one block.
- The ALU sum, immediate and carry feed it; the decoder drives its active-low load selects.

Parameters:
- W, 4, data width of A, B, Out, PC, bank and page registers. The carry flag is always 1 bit.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears every register
- sum  in  W  ALU result; load data for A, B, Out, PC
- im  in  W  instruction immediate; load data for bank and page
- carry_in  in  1  ALU carry-out
- n_ld_a  in  1  active-low load select, A
- n_ld_b  in  1  active-low load select, B
- n_ld_out  in  1  active-low load select, Out
- n_ld_pc  in  1  active-low jump select, PC
- n_ld_bank  in  1  active-low load select, bank
- n_ld_page  in  1  active-low load select, page
- a  out  W  register A
- b  out  W  register B
- out_q  out  W  output port register
- pc  out  W  program counter (ROM address)
- bank  out  W  ROM bank
- page  out  W  RAM page
- carry  out  1  carry flag

Behaviour:
- Clock and reset: one clock domain, all state updates on the rising edge of clk.
- reset=1 forces every output to 0 immediately, independent of clk, and holds them there while asserted.
- Reset dominates all load selects.
- The first edge after reset deasserts behaves normally.
- Plain registers (A, B, Out, bank, page):
  - When the select is 0 at the edge, the register takes its data input: sum for A/B/Out, im for bank/page.
  - When the select is 1, the register holds its value.
- PC:
  - When n_ld_pc=0 at the edge, pc <= sum (jump).
  - Otherwise pc <= pc+1 modulo 2^W; 4'hF wraps to 4'h0 with no flag.
  - PC never holds, except during reset.
- Carry: loaded from carry_in on every edge with no enable, so it always reflects the previous cycle's ALU carry.
- Latency: every output updates exactly one clock after the captured inputs. There is no combinational path from inputs to outputs.
- Simultaneous events:
  - Any combination of selects may be low in the same cycle.
  - Every selected register loads its own source; there is no priority between them.
- Width rules: no truncation or extension inside the block. Inputs are exactly W bits wide.
- Outputs are driven straight from flops.

Decomposition:
- Package td4e_pkg:
  - localparam WORD_W=4
  - typedef logic [WORD_W-1:0] word_t
  - shared select encoding constant LD_ACTIVE=1'b0
- Natural sub-module ld_reg, parameterised width, with an active-low load enable and asynchronous active-high clear.
  - Instantiate it six times: A, B, Out, bank, page, and carry with enable tied active.
  - The PC is written inline with its increment mux.

Test Plan:
1. Reset:
   - With all selects 1, pulse reset mid-cycle.
   - All outputs go to 0 before the next edge.
   - With reset held across 3 edges, pc stays 0.
2. PC count and wrap:
   - From reset, 17 edges with n_ld_pc=1.
   - pc reads 1, 2, …, F, 0, 1.
3. Jump:
   - pc=3, sum=4'hA, n_ld_pc=0 for one edge gives pc=A.
   - The next edge with n_ld_pc=1 gives pc=B.
4. Load/hold:
   - sum=4'h5, n_ld_a=0, n_ld_b=1 gives a=5, b=0.
   - Then sum=4'h9, n_ld_a=1, n_ld_b=0 gives a=5, b=9.
   - Out unchanged at 0 throughout.
5. Simultaneous loads:
   - sum=4'h7, im=4'h2, all selects 0 for one edge.
   - Result: a=b=out_q=pc=7 and bank=page=2.
6. Carry and reset:
   - carry_in sequence 1, 0, 1 over three edges gives carry 1, 0, 1, each one edge late.
   - Asserting reset between edges clears carry and all registers immediately.

Source files
------------

// File: rtl/td4e_pkg.sv
// Shared definitions for the TD4E register set.
// Data width, word type and load-select polarity.
package td4e_pkg;

    localparam int unsigned WORD_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    // Load selects from the decoder are active-low.
    localparam logic LD_ACTIVE = 1'b0;

endpackage

// File: rtl/ld_reg.sv
// Load-enable register with asynchronous active-high clear.
// Ports: clk, reset, n_ld (active-low load), d (data), q (state).
module ld_reg
    import td4e_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         n_ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (n_ld == LD_ACTIVE) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/td4e_reg_set.sv
// TD4E architectural registers: A, B, Out, PC, bank, page, carry.
// Ports: clk, reset, sum/im/carry_in data, n_ld_* selects, register outputs.
module td4e_reg_set
    import td4e_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sum,
    input  logic [W-1:0] im,
    input  logic         carry_in,
    input  logic         n_ld_a,
    input  logic         n_ld_b,
    input  logic         n_ld_out,
    input  logic         n_ld_pc,
    input  logic         n_ld_bank,
    input  logic         n_ld_page,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] out_q,
    output logic [W-1:0] pc,
    output logic [W-1:0] bank,
    output logic [W-1:0] page,
    output logic         carry
);

    ld_reg #(.W(W)) u_a (
        .clk   (clk),
        .reset (reset),
        .n_ld  (n_ld_a),
        .d     (sum),
        .q     (a)
    );

    ld_reg #(.W(W)) u_b (
        .clk   (clk),
        .reset (reset),
        .n_ld  (n_ld_b),
        .d     (sum),
        .q     (b)
    );

    ld_reg #(.W(W)) u_out (
        .clk   (clk),
        .reset (reset),
        .n_ld  (n_ld_out),
        .d     (sum),
        .q     (out_q)
    );

    ld_reg #(.W(W)) u_bank (
        .clk   (clk),
        .reset (reset),
        .n_ld  (n_ld_bank),
        .d     (im),
        .q     (bank)
    );

    ld_reg #(.W(W)) u_page (
        .clk   (clk),
        .reset (reset),
        .n_ld  (n_ld_page),
        .d     (im),
        .q     (page)
    );

    // Carry samples the ALU every cycle.
    ld_reg #(.W(1)) u_carry (
        .clk   (clk),
        .reset (reset),
        .n_ld  (LD_ACTIVE),
        .d     (carry_in),
        .q     (carry)
    );

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    // Jump or increment; wraps silently at all-ones.
    always_comb begin
        pc_d = pc_q + W'(1);
        if (n_ld_pc == LD_ACTIVE) begin
            pc_d = sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_td4e_reg_set.sv
// Directed self-checking bench for td4e_reg_set.
// Drives on the falling edge, samples on the falling edge after each rise.
module tb_td4e_reg_set;
    import td4e_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    word_t sum;
    word_t im;
    logic  carry_in;
    logic  n_ld_a;
    logic  n_ld_b;
    logic  n_ld_out;
    logic  n_ld_pc;
    logic  n_ld_bank;
    logic  n_ld_page;
    word_t a;
    word_t b;
    word_t out_q;
    word_t pc;
    word_t bank;
    word_t page;
    logic  carry;

    int checks = 0;
    int errors = 0;

    td4e_reg_set #(.W(WORD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sum       (sum),
        .im        (im),
        .carry_in  (carry_in),
        .n_ld_a    (n_ld_a),
        .n_ld_b    (n_ld_b),
        .n_ld_out  (n_ld_out),
        .n_ld_pc   (n_ld_pc),
        .n_ld_bank (n_ld_bank),
        .n_ld_page (n_ld_page),
        .a         (a),
        .b         (b),
        .out_q     (out_q),
        .pc        (pc),
        .bank      (bank),
        .page      (page),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sel_all(input logic v);
        n_ld_a    = v;
        n_ld_b    = v;
        n_ld_out  = v;
        n_ld_pc   = v;
        n_ld_bank = v;
        n_ld_page = v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a"}, a, 4'h0);
        chk({tag, ".b"}, b, 4'h0);
        chk({tag, ".out"}, out_q, 4'h0);
        chk({tag, ".pc"}, pc, 4'h0);
        chk({tag, ".bank"}, bank, 4'h0);
        chk({tag, ".page"}, page, 4'h0);
        chk({tag, ".carry"}, {3'b0, carry}, 4'h0);
    endtask

    initial begin
        reset    = 1'b1;
        sum      = 4'h0;
        im       = 4'h0;
        carry_in = 1'b0;
        sel_all(1'b1);
        step();
        step();
        chk_zero("por");
        reset = 1'b0;

        // PC runs, then a mid-cycle reset clears everything at once.
        step();
        step();
        chk("pre_rst_pc", pc, 4'h2);
        reset = 1'b1;
        #1;
        chk_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_hold%0d", i), pc, 4'h0);
        end
        reset = 1'b0;

        // Count through the wrap.
        for (int i = 1; i <= 17; i++) begin
            logic [4:0] e;
            step();
            e = 5'(i) & 5'h0F;
            chk($sformatf("cnt%0d", i), pc, e[3:0]);
        end
        step();
        step();
        chk("pc3", pc, 4'h3);

        // Jump then resume counting.
        sum     = 4'hA;
        n_ld_pc = 1'b0;
        step();
        chk("jump", pc, 4'hA);
        n_ld_pc = 1'b1;
        step();
        chk("jump_inc", pc, 4'hB);

        // Load / hold.
        sum    = 4'h5;
        n_ld_a = 1'b0;
        step();
        chk("ld_a.a", a, 4'h5);
        chk("ld_a.b", b, 4'h0);
        chk("ld_a.out", out_q, 4'h0);
        sum    = 4'h9;
        n_ld_a = 1'b1;
        n_ld_b = 1'b0;
        step();
        chk("ld_b.a", a, 4'h5);
        chk("ld_b.b", b, 4'h9);
        chk("ld_b.out", out_q, 4'h0);
        n_ld_b = 1'b1;
        step();
        chk("hold.a", a, 4'h5);
        chk("hold.b", b, 4'h9);

        // Every select at once.
        sum = 4'h7;
        im  = 4'h2;
        sel_all(1'b0);
        step();
        sel_all(1'b1);
        chk("all.a", a, 4'h7);
        chk("all.b", b, 4'h7);
        chk("all.out", out_q, 4'h7);
        chk("all.pc", pc, 4'h7);
        chk("all.bank", bank, 4'h2);
        chk("all.page", page, 4'h2);

        // Carry follows carry_in one edge late.
        chk("carry0", {3'b0, carry}, 4'h0);
        carry_in = 1'b1;
        #1;
        chk("carry_nocomb", {3'b0, carry}, 4'h0);
        step();
        chk("carry1", {3'b0, carry}, 4'h1);
        carry_in = 1'b0;
        step();
        chk("carry2", {3'b0, carry}, 4'h0);
        carry_in = 1'b1;
        step();
        chk("carry3", {3'b0, carry}, 4'h1);

        // Reset between edges clears all, first edge after is normal.
        reset = 1'b1;
        #1;
        chk_zero("rst2");
        #1;
        reset = 1'b0;
        step();
        chk("post_rst.pc", pc, 4'h1);
        chk("post_rst.carry", {3'b0, carry}, 4'h1);
        chk("post_rst.a", a, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
